// File: rtl/mem_arb_pkg.sv
// Shared widths, starvation limit and master identifiers for the two-master RAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 7;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the two masked requests.
// Define MEM_ARB_RR_EN for round-robin; otherwise fixed m0 priority with an m1 starvation counter.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    output logic valid_o,
    output logic winner_o
);

    master_e win;

    assign valid_o  = req0_i | req1_i;
    assign winner_o = (win == M1);

`ifdef MEM_ARB_RR_EN
    master_e last_q, last_d;

    // On contention the master that did not win most recently goes first.
    always_comb begin
        win    = M0;
        last_d = last_q;
        if (req0_i && req1_i) begin
            win = (last_q == M0) ? M1 : M0;
        end else if (req1_i) begin
            win = M1;
        end
        if (valid_o) begin
            last_d = win;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic [2:0] starve_q, starve_d;

    // m0 wins contention unless m1 has been passed over STARVE_MAX times.
    always_comb begin
        win      = M0;
        starve_d = starve_q;
        if (req0_i && req1_i) begin
            win = (starve_q == 3'(STARVE_MAX)) ? M1 : M0;
        end else if (req1_i) begin
            win = M1;
        end
        if (req1_i && win == M1) begin
            starve_d = '0;
        end else if (req1_i && starve_q != 3'(STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM with one-cycle read latency.
// Arbitration policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              ramEn_q, ramEn_d, ramWe_q, ramWe_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [DATA_W-1:0] ramWdata_q, ramWdata_d;
    logic              rvalid_q, rvalid_d;
    master_e           rid_q, rid_d;
    logic              req0Masked, req1Masked, pickValid, pickWin;

    // A request held through its own grant cycle is already being served.
    assign req0Masked = m0_req & ~gnt0_q;
    assign req1Masked = m1_req & ~gnt1_q;

    mem_arb_pick u_pick (
        .clock    (clock),
        .reset    (reset),
        .req0_i   (req0Masked),
        .req1_i   (req1Masked),
        .valid_o  (pickValid),
        .winner_o (pickWin)
    );

    always_comb begin
        gnt0_d     = pickValid & ~pickWin;
        gnt1_d     = pickValid & pickWin;
        ramEn_d    = pickValid;
        ramWe_d    = 1'b0;
        ramAddr_d  = '0;
        ramWdata_d = '0;
        if (pickValid) begin
            ramWe_d    = pickWin ? m1_we    : m0_we;
            ramAddr_d  = pickWin ? m1_addr  : m0_addr;
            ramWdata_d = pickWin ? m1_wdata : m0_wdata;
        end
        rvalid_d = ramEn_q & ~ramWe_q;
        rid_d    = gnt1_q ? M1 : M0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ramEn_q    <= 1'b0;
            ramWe_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramWdata_q <= '0;
            rvalid_q   <= 1'b0;
            rid_q      <= M0;
        end else begin
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ramEn_q    <= ramEn_d;
            ramWe_q    <= ramWe_d;
            ramAddr_q  <= ramAddr_d;
            ramWdata_q <= ramWdata_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
        end
    end

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign ram_en    = ramEn_q;
    assign ram_we    = ramWe_q;
    assign ram_addr  = ramAddr_q;
    assign ram_wdata = ramWdata_q;
    assign m0_rvalid = rvalid_q & (rid_q == M0);
    assign m1_rvalid = rvalid_q & (rid_q == M1);
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;
    // Raw requests are combinational, so busy is gated to stay low during reset.
    assign busy      = ~reset & (req0Masked | req1Masked | ramEn_q | rvalid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, multi-cycle sequences and a read-data scoreboard.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [13:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we, busy;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // Single-port RAM model with one-cycle read latency.
    logic [31:0] mem [0:16383];
    initial mem[14'h0010] = 32'hDEADBEEF;
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        r0, we0;
        logic [13:0] a0;
        logic [31:0] d0;
        logic        r1, we1;
        logic [13:0] a1;
        logic [31:0] d1;
        logic        g0, g1;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } sb_t;

    sb_t         sbq[$];
    logic [31:0] shadow [int];
    logic        tbLast;
    int          checks = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic popCheck(input logic id, input logic [31:0] data);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_rvalid: got rvalid on m%0d, expected none", id);
        end else begin
            e = sbq.pop_front();
            chk("rvalid_master", 32'(id), 32'(e.id));
            chk("rdata", data, e.data);
        end
    endtask

    // Scoreboard consumer and per-cycle grant exclusivity.
    always @(negedge clock) begin
        chk("gnt_mutex", 32'(m0_gnt & m1_gnt), 32'd0);
        if (m0_rvalid) popCheck(1'b0, m0_rdata);
        if (m1_rvalid) popCheck(1'b1, m1_rdata);
    end

    task automatic dropReqs();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
    endtask

    // Grant cycle: check the issued access and record expected read data; next cycle: rvalid timing.
    task automatic checkOutput(input string name, input vec_t v);
        logic        we;
        logic [13:0] a;
        logic [31:0] d;
        @(negedge clock);
        dropReqs();
        chk({name, "_gnt0"}, 32'(m0_gnt), 32'(v.g0));
        chk({name, "_gnt1"}, 32'(m1_gnt), 32'(v.g1));
        chk({name, "_ram_en"}, 32'(ram_en), 32'(v.g0 | v.g1));
        if (v.g0 | v.g1) begin
            we = v.g1 ? v.we1 : v.we0;
            a  = v.g1 ? v.a1  : v.a0;
            d  = v.g1 ? v.d1  : v.d0;
            chk({name, "_ram_we"}, 32'(ram_we), 32'(we));
            chk({name, "_ram_addr"}, 32'(ram_addr), 32'(a));
            if (we) begin
                chk({name, "_ram_wdata"}, ram_wdata, d);
                shadow[int'(a)] = d;
            end else begin
                sbq.push_back('{id: v.g1, data: shadow[int'(a)]});
            end
            tbLast = v.g1;
        end else begin
            chk({name, "_ram_we_idle"}, 32'(ram_we), 32'd0);
        end
        @(negedge clock);
        chk({name, "_rvalid0"}, 32'(m0_rvalid), 32'(v.g0 & ~v.we0));
        chk({name, "_rvalid1"}, 32'(m1_rvalid), 32'(v.g1 & ~v.we1));
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        dropReqs();
        m1_req = 1'b1;
        @(negedge clock);
        chk("reset_outputs", 32'(|{m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                                  ram_en, ram_we, ram_addr, ram_wdata, busy}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        m1_req = 1'b0;
        tbLast = 1'b1;
    endtask

    vec_t vecs[11];
    vec_t sv;

    initial begin
        shadow[16] = 32'hDEADBEEF;
        tbLast = 1'b1;
        vecs[0]  = '{1, 0, 14'h0010, 0,            0, 0, 0, 0,                    1, 0};
        vecs[1]  = '{0, 0, 0, 0,                   1, 1, 14'h0020, 32'h12345678,  0, 1};
        vecs[2]  = '{1, 0, 14'h0020, 0,            0, 0, 0, 0,                    1, 0};
        vecs[3]  = '{1, 0, 14'h0010, 0,            1, 0, 14'h0020, 0,             !RR, RR};
        vecs[4]  = '{1, 0, 14'h0020, 0,            1, 0, 14'h0010, 0,             1, 0};
        vecs[5]  = '{0, 0, 0, 0,                   1, 0, 14'h0010, 0,             0, 1};
        vecs[6]  = '{0, 0, 0, 0,                   0, 0, 0, 0,                    0, 0};
        vecs[7]  = '{1, 1, 14'h0030, 32'hAAAA5555, 0, 0, 0, 0,                    1, 0};
        vecs[8]  = '{0, 0, 0, 0,                   1, 0, 14'h0030, 0,             0, 1};
        vecs[9]  = '{0, 0, 0, 0,                   1, 1, 14'h3FFF, 32'h13579BDF,  0, 1};
        vecs[10] = '{1, 0, 14'h3FFF, 0,            0, 0, 0, 0,                    1, 0};

        doReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Repeated one-cycle contention: fixed priority starves m1 for at most 7 contentions.
        for (int k = 0; k < 8; k++) begin
            sv = '{1, 0, 14'h0010, 0, 1, 0, 14'h0030, 0, 0, 0};
            if (RR) sv.g1 = ~tbLast;
            else    sv.g1 = (k == 7);
            sv.g0 = ~sv.g1;
`ifndef MEM_ARB_RR_EN
            if (k == 7) chk("starve_full", 32'(dut.u_pick.starve_q), 32'd7);
`endif
            applyStimulus(sv);
            checkOutput($sformatf("contend%0d", k), sv);
        end
`ifndef MEM_ARB_RR_EN
        chk("starve_cleared", 32'(dut.u_pick.starve_q), 32'd0);
`endif

        // Both masters hold requests: masking alone forces strict alternation with no bubble.
        doReset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 14'h0040; m0_wdata = 32'h0000_0A0A;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h0041; m1_wdata = 32'h0000_0B0B;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk($sformatf("alt%0d_gnt0", k), 32'(m0_gnt), 32'(k % 2 == 0));
            chk($sformatf("alt%0d_gnt1", k), 32'(m1_gnt), 32'(k % 2 == 1));
            chk($sformatf("alt%0d_ram_en", k), 32'(ram_en), 32'd1);
        end
        dropReqs();
        @(negedge clock);
        chk("alt_idle_ram_en", 32'(ram_en), 32'd0);
        chk("alt_idle_busy", 32'(busy), 32'd0);

        // Write by m1 immediately followed by a read of the same word by m0.
        @(negedge clock);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h0020; m1_wdata = 32'h0BADF00D;
        @(negedge clock);
        chk("raw_m1_gnt", 32'(m1_gnt), 32'd1);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0020;
        @(negedge clock);
        chk("raw_m0_gnt", 32'(m0_gnt), 32'd1);
        sbq.push_back('{id: 1'b0, data: 32'h0BADF00D});
        m0_req = 1'b0;
        @(negedge clock);
        chk("raw_m0_rvalid", 32'(m0_rvalid), 32'd1);

        // Reset lands while a read grant is visible: the read must be dropped.
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0010;
        @(negedge clock);
        chk("rst_read_gnt", 32'(m0_gnt), 32'd1);
        m0_req = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_outputs", 32'(|{m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                                    ram_en, ram_we, ram_addr, ram_wdata, busy}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0010;
        @(negedge clock);
        chk("post_rst_gnt0", 32'(m0_gnt), 32'd1);
        chk("post_rst_gnt1", 32'(m1_gnt), 32'd0);
        sbq.push_back('{id: 1'b0, data: 32'hDEADBEEF});
        dropReqs();
        repeat (4) @(negedge clock);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: m0_req  in  1  CPU data-port request, held until granted.
REQ-004 SHALL have ports: m0_we  in  1  CPU write enable (1 = store, 0 = load).
REQ-005 SHALL have ports: m0_addr  in  14  CPU word address.
REQ-006 SHALL have ports: m0_wdata  in  32  CPU store data.
REQ-007 SHALL have ports: m0_gnt  out  1  one-cycle grant pulse to CPU.
REQ-008 SHALL have ports: m0_rvalid  out  1  CPU load data valid.
REQ-009 SHALL have ports: m0_rdata  out  32  CPU load data.
REQ-010 SHALL have ports: m1_req, m1_we, m1_addr[13:0], m1_wdata[31:0], m1_gnt, m1_rvalid, m1_rdata[31:0], identical in meaning to m0, serving the program loader / IO master.
REQ-011 SHALL have ports: ram_en  out  1;  ram_we  out  1;  ram_addr  out  14;  ram_wdata  out  32;  ram_rdata  in  32, driving a single-port RAM with 1-cycle read latency.
REQ-012 SHALL have port: busy  out  1  high when any access is in flight or pending.

Function
REQ-013 SHALL sample requests in cycle N and issue the winner's access in cycle N+1 (ram_en=1, mx_gnt=1, registered).
REQ-014 SHALL assert mx_rvalid with ram_rdata routed to mx_rdata in cycle N+2 for reads only; writes produce no rvalid.
REQ-015 SHALL mask a master's req in any cycle its gnt is high, so a stale held request is never granted twice.
REQ-016 SHALL sustain one access per cycle when both masters request alternately (pipelined, no idle bubble).
REQ-017 SHALL drive ram_we, ram_addr, ram_wdata from the granted master's registered we/addr/wdata; ram_we=0 when ram_en=0.
REQ-018 SHALL grant at most one master per cycle; m0_gnt and m1_gnt never high together.
REQ-019 SHALL, with no request, hold ram_en=0 and both gnt low.
REQ-020 SHALL, on simultaneous requests, resolve by the arbitration policy of REQ-025/REQ-026.
REQ-021 SHALL make a read issued in cycle N+1 to an address written in cycle N return the new data.
REQ-022 SHALL set busy = any unmasked req | ram_en | pending rvalid.

Reset
REQ-023 SHALL, while reset is high, force all outputs to 0, clear the pipeline (in-flight reads dropped, no rvalid after release), set the round-robin pointer to "last=m1" and clear the starvation counter.
REQ-024 SHALL resume arbitration on the first rising clock edge after reset falls.

Configuration
REQ-025 SHALL, with macro MEM_ARB_RR_EN defined, use round-robin: on contention, grant the master not granted most recently; the pointer updates on every grant.
REQ-026 SHALL, without MEM_ARB_RR_EN, use fixed priority m0 > m1 plus a 3-bit starvation counter that increments each cycle m1 is pending and not granted; at count 7 m1 wins the next contention; the counter clears on m1 grant.

Structure
REQ-027 SHALL place ADDR_W=14, DATA_W=32, STARVE_MAX=7 and the master-id enum (M0, M1) in shared package mem_arb_pkg.
REQ-028 SHALL implement the winner-selection logic (policy, pointer, starvation counter) in sub-module mem_arb_pick; the pipeline and RAM muxing remain in mem_arbiter.

Verification
REQ-029 SHALL cover: single m0 read at addr 0x0010 (RAM holds 0xDEADBEEF) -> m0_gnt in N+1, m0_rvalid with 0xDEADBEEF in N+2.
REQ-030 SHALL cover: m0 and m1 request together continuously, RR build -> grants alternate m0, m1, m0, ...; ram_en high every cycle.
REQ-031 SHALL cover: non-RR build, m0 requests continuously, m1 requests -> m1 granted after at most 8 cycles waiting, then counter reads 0.
REQ-032 SHALL cover: m1 writes 0x12345678 to 0x0020, m0 reads 0x0020 in the next cycle -> m0_rdata = 0x12345678.
REQ-033 SHALL cover: reset asserted the cycle after an m0 read grant -> no m0_rvalid, all outputs 0, first post-reset contention grants m0.
